// File: rtl/plot_queue.sv
// -----------------------------------------------------------------------------
// plot_queue
//
// Buffered pixel-write stage between the bird/hunter draw datapath and
// vga_adapter. Plot requests arrive on a valid/ready handshake. Off-screen
// pixels are consumed and dropped. On-screen pixels are queued in a small FIFO
// and replayed to vga_adapter at no more than one plot strobe per clock. This
// lets the draw FSM emit pixels in bursts, and anything outside the 160x120
// screen still never reaches the frame buffer.
//
// Optional feature (compile-time macro PLOT_CLIP_STATS_EN):
//   When it is defined, a saturating 8-bit clip_count output counts every
//   clipped handshake. When it is undefined, the port and the counter are
//   absent.
//
// Ports:
//   clock       in   1     system clock
//   resetn      in   1     asynchronous active-low reset
//   in_valid    in   1     draw datapath presents a pixel
//   in_x        in   8     pixel x
//   in_y        in   7     pixel y
//   in_colour   in   3     pixel colour (RGB, 1 bit each)
//   in_ready    out  1     queue can accept (registered, equals !full)
//   stall       in   1     1 = hold output side, no plot issued
//   plot        out  1     one-cycle write strobe to vga_adapter
//   x           out  8     registered pixel x
//   y           out  7     registered pixel y
//   colour      out  3     registered colour
//   level       out  AW+1  FIFO occupancy, 0..DEPTH
//   clip_count  out  8     clipped-handshake count (PLOT_CLIP_STATS_EN only)
// -----------------------------------------------------------------------------
module plot_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          in_valid,
    input  logic [7:0]    in_x,
    input  logic [6:0]    in_y,
    input  logic [2:0]    in_colour,
    output logic          in_ready,
    input  logic          stall,
    output logic          plot,
    output logic [7:0]    x,
    output logic [6:0]    y,
    output logic [2:0]    colour,
    output logic [AW:0]   level
`ifdef PLOT_CLIP_STATS_EN
    ,
    output logic [7:0]    clip_count
`endif
);

    localparam int             EW        = 18;  // {x, y, colour}
    localparam logic [AW:0]    LEVEL_MAX = (AW+1)'(DEPTH);

    // Storage: plain array, written on store, read only into the registered
    // output stage so it maps onto block RAM.
    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [AW:0]   level_reg;
    logic [AW:0]   level_next;
    logic          in_ready_reg;
    logic          plot_reg;
    logic [7:0]    x_reg;
    logic [6:0]    y_reg;
    logic [2:0]    colour_reg;

    logic handshake;
    logic clip;
    logic store;
    logic pop;

    // The comparisons are one bit wider than the coordinates, so an X_MAX of
    // 256 (no clipping) still works.
    assign clip      = ({1'b0, in_x} >= 9'(X_MAX)) || ({1'b0, in_y} >= 8'(Y_MAX));
    assign handshake = in_valid & in_ready_reg;
    assign store     = handshake & ~clip;
    // pop depends only on the registered level. A pixel stored at edge N is
    // therefore popped at N+1 at the earliest, and nothing falls through
    // combinationally.
    assign pop       = (level_reg != '0) & ~stall;

    always_comb begin
        level_next = level_reg;
        case ({store, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (store) begin
            mem[wptr_reg] <= {in_x, in_y, in_colour};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            level_reg    <= '0;
            in_ready_reg <= 1'b1;
            plot_reg     <= 1'b0;
            x_reg        <= '0;
            y_reg        <= '0;
            colour_reg   <= '0;
        end else begin
            level_reg    <= level_next;
            // in_ready is registered from the next level. A pop on the edge
            // where the queue is full cannot admit a push on that same edge.
            in_ready_reg <= (level_next != LEVEL_MAX);
            plot_reg     <= pop;
            if (store) begin
                wptr_reg <= wptr_reg + 1'b1;   // DEPTH is 2**AW: natural wrap
            end
            if (pop) begin
                rptr_reg   <= rptr_reg + 1'b1;
                x_reg      <= mem[rptr_reg][17:10];
                y_reg      <= mem[rptr_reg][9:3];
                colour_reg <= mem[rptr_reg][2:0];
            end
        end
    end

`ifdef PLOT_CLIP_STATS_EN
    logic [7:0] clip_count_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clip_count_reg <= '0;
        end else if (handshake && clip && (clip_count_reg != 8'hFF)) begin
            clip_count_reg <= clip_count_reg + 1'b1;
        end
    end

    assign clip_count = clip_count_reg;
`endif

    assign in_ready = in_ready_reg;
    assign plot     = plot_reg;
    assign x        = x_reg;
    assign y        = y_reg;
    assign colour   = colour_reg;
    assign level    = level_reg;

endmodule
